mipi_csi2_packet_generator: RTL
===============================

Name: mipi_csi2_packet_generator

Overview:
- Transmit-side counterpart of the MIPI image extractor. Packs a raw pixel byte stream into a CSI-2 byte-lane stream: a Frame Start short packet, then NUM_LINES long packets, then a Frame End short packet.
- Output format is exactly what mipi_image_extractor consumes. Used as a loopback/test source in the test_board and as the camera emulator for extractor regression.

Parameters:
- LINE_BYTES, 1280: payload bytes per line; also the long-packet word count (WC).
- NUM_LINES, 800: long packets per frame.
- LINE_DT, 6'h2C: data type of line packets (RAW12).
- VC, 2'd0: virtual channel placed in DI[7:6] of every packet.
- GAP_CYCLES, 50: idle cycles (mipi_data_valid low) after every packet; range 1..255.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse that begins one frame; ignored while busy.
- pixel_data  in  8  payload byte.
- pixel_valid  in  1  pixel_data is valid.
- pixel_ready  out  1  byte accepted when pixel_valid and pixel_ready are both high.
- mipi_data  out  8  CSI-2 byte stream, registered.
- mipi_data_valid  out  1  mipi_data is valid this cycle.
- busy  out  1  high from the cycle after an accepted frame_start until FE-gap completion.
- frame_num  out  16  frame number of the current or last frame.
- line_count  out  16  long packets sent in the current frame.

Behaviour:
- Reset values:
  - mipi_data = 0, mipi_data_valid = 0, pixel_ready = 0, busy = 0.
  - frame_num = 0, line_count = 0, state = IDLE.
  - Reset mid-packet aborts immediately; no footer or FE is emitted.
- Packet header is 4 bytes in order: DI = {VC, DT}, WC[7:0], WC[15:8], ECC.
  - ECC is the CSI-2 6-bit Hamming code over the 24 bits {WC_hi, WC_lo, DI}; ECC[7:6] = 0.
  - Computed combinationally from registered DI/WC.
- Short packets use WC = frame_num.
  - FS uses DT 0x00; FE uses DT 0x01.
- frame_num update:
  - Incremented when frame_start is accepted, before the FS header.
  - Wraps 0xFFFF -> 0x0001; the value 0 is never sent.
  - The first frame after reset is 0x0001.
- FSM: IDLE -> FS_HDR(4) -> GAP -> {LINE_HDR(4) -> PAYLOAD(LINE_BYTES) -> [CRC(2)] -> GAP} x NUM_LINES -> FE_HDR(4) -> GAP -> IDLE.
  - GAP lasts exactly GAP_CYCLES cycles with mipi_data_valid = 0 and mipi_data held.
- Latency: frame_start sampled high at edge N -> first DI byte valid at edge N+1.
  - Header bytes are on consecutive cycles.
- PAYLOAD:
  - pixel_ready = 1 only in PAYLOAD while bytes remain.
  - An accepted byte appears on mipi_data one cycle later with mipi_data_valid = 1.
  - If pixel_valid is low, mipi_data_valid is 0 that cycle (stall); no byte is lost or duplicated.
  - pixel_ready deasserts combinationally once LINE_BYTES bytes are accepted.
  - The byte counter is 16 bits and compares against LINE_BYTES-1.
- line_count increments when the last payload byte (or CRC byte, if enabled) is emitted.
  - After line NUM_LINES the FSM enters FE_HDR instead of LINE_HDR.
  - line_count clears on frame_start acceptance.
- frame_start arriving in the same cycle as the final FE-gap cycle is ignored. A frame_start is accepted only in IDLE.
- pixel_ready is never asserted outside PAYLOAD, even if pixel_valid is high.

Optional Feature:
- Macro: MIPI_TX_CRC_EN.
- Defined:
  - Each long packet is followed by a 2-byte CRC footer: CRC[7:0] then CRC[15:8].
  - CRC-16 polynomial x^16+x^12+x^5+1, reflected (0x8408), seed 0xFFFF, updated per payload byte LSB-first.
  - CRC is reset at each LINE_HDR and is not computed over the header.
- Undefined:
  - No footer; GAP follows the last payload byte directly.
  - No CRC logic is synthesized.

Test Plan:
- Reset, pulse frame_start, pixel_valid tied 1 -> first four valid bytes 00 01 00 1A, then 50 idle cycles, then line header 2C 00 05 13.
- Feed 1280 bytes with value = index mod 256 -> mipi_data sequence 00..FF repeating, byte count exactly 1280; pixel_ready low afterwards; 4-line frame (NUM_LINES=4) ends with 01 01 00 <ECC>.
- Toggle pixel_valid every other cycle during PAYLOAD -> mipi_data_valid gaps mirror the stalls; payload content is still intact and in order.
- Run 2 frames, then force frame_num to 0xFFFF -> next FS WC = 0x0001; a frame_start pulse while busy is ignored (frame_num unchanged).
- MIPI_TX_CRC_EN with LINE_BYTES=4 and payload 01 02 03 04 -> footer matches a reference CRC model; with the macro undefined, the byte after 04 is non-valid.
- Assert rst mid-PAYLOAD -> mipi_data_valid = 0 and busy = 0 on the same cycle; the next frame_start produces a clean FS with WC 0x0001.

Source files
------------

// File: rtl/mipi_csi2_packet_generator.sv
`default_nettype none
// ============================================================================
// Module      : mipi_csi2_packet_generator
// Description : Packs a raw pixel byte stream into a CSI-2 byte-lane stream:
//               a Frame Start short packet, NUM_LINES long packets, then a
//               Frame End short packet, each followed by GAP_CYCLES idle
//               cycles. Serves as a camera emulator for the image extractor.
// Ports       : clk, rst (async, active high)
//               frame_start              - pulse to begin a frame (IDLE only)
//               pixel_data/valid/ready   - payload byte handshake
//               mipi_data/mipi_data_valid- registered CSI-2 byte stream
//               busy                     - frame in progress
//               frame_num, line_count    - frame / line progress
// Options     : `define MIPI_TX_CRC_EN adds a 2-byte CRC-16 footer to every
//               long packet (poly 0x8408 reflected, seed 0xFFFF).
// Revision    : 1.0 - initial release
// ============================================================================
module mipi_csi2_packet_generator #(
    parameter int         LINE_BYTES = 1280,
    parameter int         NUM_LINES  = 800,
    parameter logic [5:0] LINE_DT    = 6'h2C,
    parameter logic [1:0] VC         = 2'd0,
    parameter int         GAP_CYCLES = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [7:0]  pixel_data,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    output logic [7:0]  mipi_data,
    output logic        mipi_data_valid,
    output logic        busy,
    output logic [15:0] frame_num,
    output logic [15:0] line_count
);

    localparam logic [5:0]  c_dt_fs    = 6'h00;
    localparam logic [5:0]  c_dt_fe    = 6'h01;
    localparam logic [15:0] c_wc_line  = 16'(LINE_BYTES);
    localparam logic [15:0] c_last_idx = 16'(LINE_BYTES - 1);
    localparam logic [15:0] c_lines    = 16'(NUM_LINES);
    localparam logic [7:0]  c_gap      = 8'(GAP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FS_HDR   = 3'd1,
        S_GAP      = 3'd2,
        S_LINE_HDR = 3'd3,
        S_PAYLOAD  = 3'd4,
        S_CRC      = 3'd5,
        S_FE_HDR   = 3'd6
    } state_t;

    state_t      r_state;
    logic [1:0]  r_hdr_idx;     // next header byte to emit (byte 0 goes out on entry)
    logic [7:0]  r_gap_cnt;
    logic [15:0] r_byte_cnt;
    logic [15:0] r_line_cnt;
    logic [15:0] r_frame_num;
    logic [7:0]  r_di;
    logic [15:0] r_wc;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_busy;
    logic        r_frame_end;   // FE header already sent; next gap returns to IDLE

    logic [23:0] w_hdr;
    logic [7:0]  w_ecc;
    logic [15:0] w_frame_num_next;

    // Frame number skips 0 on wrap so a receiver never sees WC = 0 in FS/FE.
    assign w_frame_num_next = (r_frame_num == 16'hFFFF) ? 16'h0001 : r_frame_num + 16'd1;

    // CSI-2 header ECC over {WC_hi, WC_lo, DI}
    assign w_hdr = {r_wc, r_di};
    assign w_ecc[0] = w_hdr[0]  ^ w_hdr[1]  ^ w_hdr[2]  ^ w_hdr[4]  ^ w_hdr[5]  ^ w_hdr[7]  ^
                      w_hdr[10] ^ w_hdr[11] ^ w_hdr[13] ^ w_hdr[16] ^ w_hdr[20] ^ w_hdr[21] ^
                      w_hdr[22] ^ w_hdr[23];
    assign w_ecc[1] = w_hdr[0]  ^ w_hdr[1]  ^ w_hdr[3]  ^ w_hdr[4]  ^ w_hdr[6]  ^ w_hdr[8]  ^
                      w_hdr[10] ^ w_hdr[12] ^ w_hdr[14] ^ w_hdr[17] ^ w_hdr[20] ^ w_hdr[21] ^
                      w_hdr[22] ^ w_hdr[23];
    assign w_ecc[2] = w_hdr[0]  ^ w_hdr[2]  ^ w_hdr[3]  ^ w_hdr[5]  ^ w_hdr[6]  ^ w_hdr[9]  ^
                      w_hdr[11] ^ w_hdr[12] ^ w_hdr[15] ^ w_hdr[18] ^ w_hdr[20] ^ w_hdr[21] ^
                      w_hdr[22];
    assign w_ecc[3] = w_hdr[1]  ^ w_hdr[2]  ^ w_hdr[3]  ^ w_hdr[7]  ^ w_hdr[8]  ^ w_hdr[9]  ^
                      w_hdr[13] ^ w_hdr[14] ^ w_hdr[15] ^ w_hdr[19] ^ w_hdr[20] ^ w_hdr[21] ^
                      w_hdr[23];
    assign w_ecc[4] = w_hdr[4]  ^ w_hdr[5]  ^ w_hdr[6]  ^ w_hdr[7]  ^ w_hdr[8]  ^ w_hdr[9]  ^
                      w_hdr[16] ^ w_hdr[17] ^ w_hdr[18] ^ w_hdr[19] ^ w_hdr[20] ^ w_hdr[22] ^
                      w_hdr[23];
    assign w_ecc[5] = w_hdr[10] ^ w_hdr[11] ^ w_hdr[12] ^ w_hdr[13] ^ w_hdr[14] ^ w_hdr[15] ^
                      w_hdr[16] ^ w_hdr[17] ^ w_hdr[18] ^ w_hdr[19] ^ w_hdr[21] ^ w_hdr[22] ^
                      w_hdr[23];
    assign w_ecc[7:6] = 2'b00;

`ifdef MIPI_TX_CRC_EN
    logic [15:0] r_crc;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] crc;
        crc = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc[0] ^ data[i]) crc = (crc >> 1) ^ 16'h8408;
            else                  crc = crc >> 1;
        end
        return crc;
    endfunction
`endif

    // Leaving PAYLOAD on the last accepted byte drops ready without extra logic.
    assign pixel_ready     = (r_state == S_PAYLOAD);
    assign mipi_data       = r_data;
    assign mipi_data_valid = r_valid;
    assign busy            = r_busy;
    assign frame_num       = r_frame_num;
    assign line_count      = r_line_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hdr_idx   <= 2'd0;
            r_gap_cnt   <= 8'd0;
            r_byte_cnt  <= 16'd0;
            r_line_cnt  <= 16'd0;
            r_frame_num <= 16'd0;
            r_di        <= 8'd0;
            r_wc        <= 16'd0;
            r_data      <= 8'd0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_end <= 1'b0;
`ifdef MIPI_TX_CRC_EN
            r_crc       <= 16'hFFFF;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    if (frame_start) begin
                        r_frame_num <= w_frame_num_next;
                        r_line_cnt  <= 16'd0;
                        r_busy      <= 1'b1;
                        r_frame_end <= 1'b0;
                        r_di        <= {VC, c_dt_fs};
                        r_wc        <= w_frame_num_next;
                        r_data      <= {VC, c_dt_fs};
                        r_valid     <= 1'b1;
                        r_hdr_idx   <= 2'd1;
                        r_state     <= S_FS_HDR;
                    end
                end

                S_FS_HDR, S_LINE_HDR, S_FE_HDR: begin
                    r_valid   <= 1'b1;
                    r_hdr_idx <= r_hdr_idx + 2'd1;
                    case (r_hdr_idx)
                        2'd1:    r_data <= r_wc[7:0];
                        2'd2:    r_data <= r_wc[15:8];
                        default: begin
                            r_data    <= w_ecc;
                            r_gap_cnt <= 8'd0;
                            if (r_state == S_LINE_HDR) begin
                                r_byte_cnt <= 16'd0;
                                r_state    <= S_PAYLOAD;
                            end else begin
                                r_state    <= S_GAP;
                            end
                        end
                    endcase
                end

                S_GAP: begin
                    if (r_gap_cnt == c_gap) begin
                        if (r_frame_end) begin
                            r_busy  <= 1'b0;
                            r_valid <= 1'b0;
                            r_state <= S_IDLE;
                        end else if (r_line_cnt == c_lines) begin
                            r_frame_end <= 1'b1;
                            r_di        <= {VC, c_dt_fe};
                            r_wc        <= r_frame_num;
                            r_data      <= {VC, c_dt_fe};
                            r_valid     <= 1'b1;
                            r_hdr_idx   <= 2'd1;
                            r_state     <= S_FE_HDR;
                        end else begin
                            r_di      <= {VC, LINE_DT};
                            r_wc      <= c_wc_line;
                            r_data    <= {VC, LINE_DT};
                            r_valid   <= 1'b1;
                            r_hdr_idx <= 2'd1;
                            r_state   <= S_LINE_HDR;
`ifdef MIPI_TX_CRC_EN
                            r_crc     <= 16'hFFFF;
`endif
                        end
                    end else begin
                        r_valid   <= 1'b0;
                        r_gap_cnt <= r_gap_cnt + 8'd1;
                    end
                end

                S_PAYLOAD: begin
                    if (pixel_valid) begin
                        r_data     <= pixel_data;
                        r_valid    <= 1'b1;
                        r_byte_cnt <= r_byte_cnt + 16'd1;
`ifdef MIPI_TX_CRC_EN
                        r_crc      <= crc16_byte(r_crc, pixel_data);
                        if (r_byte_cnt == c_last_idx) begin
                            r_hdr_idx <= 2'd0;
                            r_state   <= S_CRC;
                        end
`else
                        if (r_byte_cnt == c_last_idx) begin
                            r_line_cnt <= r_line_cnt + 16'd1;
                            r_gap_cnt  <= 8'd0;
                            r_state    <= S_GAP;
                        end
`endif
                    end else begin
                        r_valid <= 1'b0;
                    end
                end

`ifdef MIPI_TX_CRC_EN
                S_CRC: begin
                    r_valid <= 1'b1;
                    if (r_hdr_idx == 2'd0) begin
                        r_data    <= r_crc[7:0];
                        r_hdr_idx <= 2'd1;
                    end else begin
                        r_data     <= r_crc[15:8];
                        r_line_cnt <= r_line_cnt + 16'd1;
                        r_gap_cnt  <= 8'd0;
                        r_state    <= S_GAP;
                    end
                end
`endif

                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
